// File: rtl/calc_multiport_engine.sv
// calc_multiport_engine
// Multi-port calculator engine. Each port captures two-cycle tagged commands
// into its own FIFO. One shared ALU serves the non-empty FIFOs round-robin,
// one command per cycle, and returns each result on the issuing port.
module calc_multiport_engine #(
    parameter int NPORT    = 4,
    parameter int REG_WD   = 32,
    parameter int INSTR_WD = 4,
    parameter int RSP_WD   = 2,
    parameter int TAG_WD   = 2,
    parameter int QDEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [0:NPORT*INSTR_WD-1]     op,
    input  logic [0:NPORT*REG_WD-1]       data_in,
    input  logic [0:NPORT*TAG_WD-1]       tag_in,
    output logic [0:NPORT-1]              busy,
    output logic [0:NPORT*RSP_WD-1]       resp,
    output logic [0:NPORT*REG_WD-1]       data_out,
    output logic [0:NPORT*TAG_WD-1]       tag_out
);

    localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int QW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW     = $clog2(QDEPTH + 1);
    localparam int SW     = (REG_WD > 1) ? $clog2(REG_WD) : 1;
    localparam int CMD_WD = INSTR_WD + TAG_WD + 2 * REG_WD;

    // Capture states: DROP swallows the operand cycle of a refused command.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP2  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [RSP_WD-1:0] RSP_OK  = RSP_WD'(1);
    localparam logic [RSP_WD-1:0] RSP_ERR = RSP_WD'(2);

    // Per-port FIFO heads, seen by the shared arbiter/ALU.
    logic [INSTR_WD-1:0] head_op  [NPORT];
    logic [TAG_WD-1:0]   head_tag [NPORT];
    logic [REG_WD-1:0]   head_a   [NPORT];
    logic [REG_WD-1:0]   head_b   [NPORT];
    logic [0:NPORT-1]    not_empty;
    logic [0:NPORT-1]    pop;

    logic [PW-1:0]       last_grant_reg;
    logic                grant_valid;
    logic [PW-1:0]       grant_idx;
    int                  cand;

    logic [INSTR_WD-1:0] sel_op;
    logic [TAG_WD-1:0]   sel_tag;
    logic [REG_WD-1:0]   sel_a;
    logic [REG_WD-1:0]   sel_b;
    logic [RSP_WD-1:0]   alu_resp;
    logic [REG_WD-1:0]   alu_data;
    logic [REG_WD:0]     sum;

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            logic [1:0]          state_reg;
            logic [INSTR_WD-1:0] op_reg;
            logic [TAG_WD-1:0]   tag_reg;
            logic [REG_WD-1:0]   op1_reg;
            logic [CMD_WD-1:0]   mem [QDEPTH];
            logic [QW-1:0]       wr_ptr_reg;
            logic [QW-1:0]       rd_ptr_reg;
            logic [CW-1:0]       count_reg;
            logic [INSTR_WD-1:0] port_op;
            logic [REG_WD-1:0]   port_data;
            logic [TAG_WD-1:0]   port_tag;
            logic                push;
            logic [CW:0]         occupancy;
            logic [CMD_WD-1:0]   head;

            assign port_op   = op[gi*INSTR_WD +: INSTR_WD];
            assign port_data = data_in[gi*REG_WD +: REG_WD];
            assign port_tag  = tag_in[gi*TAG_WD +: TAG_WD];

            // The operand-2 cycle always completes a command into the FIFO.
            assign push      = (state_reg == ST_OP2);
            // A command in flight already owns a FIFO slot for busy purposes.
            assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, push};
            assign busy[gi]  = (occupancy >= (CW+1)'(QDEPTH));

            // Two-cycle command capture; a command started while busy is dropped whole.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                    op_reg    <= '0;
                    tag_reg   <= '0;
                    op1_reg   <= '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (port_op != '0) begin
                                if (busy[gi]) begin
                                    state_reg <= ST_DROP;
                                end else begin
                                    state_reg <= ST_OP2;
                                    op_reg    <= port_op;
                                    tag_reg   <= port_tag;
                                    op1_reg   <= port_data;
                                end
                            end
                        end
                        default: state_reg <= ST_IDLE;
                    endcase
                end
            end

            // FIFO storage; contents need no reset since pointers define validity.
            always_ff @(posedge clock) begin
                if (push) begin
                    mem[wr_ptr_reg] <= {op_reg, tag_reg, op1_reg, port_data};
                end
            end

            // FIFO pointers and occupancy; simultaneous push and pop keep the count.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= (wr_ptr_reg == QW'(QDEPTH-1)) ? '0 : wr_ptr_reg + QW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= (rd_ptr_reg == QW'(QDEPTH-1)) ? '0 : rd_ptr_reg + QW'(1);
                    end
                    case ({push, pop[gi]})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            assign head          = mem[rd_ptr_reg];
            assign head_op[gi]   = head[CMD_WD-1 -: INSTR_WD];
            assign head_tag[gi]  = head[2*REG_WD +: TAG_WD];
            assign head_a[gi]    = head[REG_WD +: REG_WD];
            assign head_b[gi]    = head[REG_WD-1:0];
            assign not_empty[gi] = (count_reg != '0);
            assign pop[gi]       = grant_valid && (grant_idx == PW'(gi));
        end
    endgenerate

    // Round-robin search starting just after the last granted port.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NPORT; i++) begin
            cand = (int'(last_grant_reg) + i) % NPORT;
            if (!grant_valid && not_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    assign sel_op  = head_op[grant_idx];
    assign sel_tag = head_tag[grant_idx];
    assign sel_a   = head_a[grant_idx];
    assign sel_b   = head_b[grant_idx];

    // Unsigned ALU; any arithmetic fault or unknown opcode reports an error with zero data.
    always_comb begin
        alu_resp = RSP_ERR;
        alu_data = '0;
        sum      = '0;
        case (sel_op)
            INSTR_WD'(1): begin
                sum = {1'b0, sel_a} + {1'b0, sel_b};
                if (!sum[REG_WD]) begin
                    alu_resp = RSP_OK;
                    alu_data = sum[REG_WD-1:0];
                end
            end
            INSTR_WD'(2): begin
                if (sel_b <= sel_a) begin
                    alu_resp = RSP_OK;
                    alu_data = sel_a - sel_b;
                end
            end
            INSTR_WD'(5): begin
                alu_resp = RSP_OK;
                alu_data = sel_a << sel_b[SW-1:0];
            end
            INSTR_WD'(6): begin
                alu_resp = RSP_OK;
                alu_data = sel_a >> sel_b[SW-1:0];
            end
            default: ;
        endcase
    end

    // One-cycle result pulse on the granted port; all other ports read zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp           <= '0;
            data_out       <= '0;
            tag_out        <= '0;
            last_grant_reg <= PW'(NPORT-1);
        end else begin
            resp     <= '0;
            data_out <= '0;
            tag_out  <= '0;
            if (grant_valid) begin
                resp[int'(grant_idx)*RSP_WD +: RSP_WD]     <= alu_resp;
                data_out[int'(grant_idx)*REG_WD +: REG_WD] <= alu_data;
                tag_out[int'(grant_idx)*TAG_WD +: TAG_WD]  <= sel_tag;
                last_grant_reg                             <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_calc_multiport_engine.sv
// tb_calc_multiport_engine
// Directed checks of latency, ALU rules, arbitration order and reset, plus a
// randomized flood compared cycle by cycle against a queue-based model.
module tb_calc_multiport_engine;

    localparam int NPORT    = 4;
    localparam int REG_WD   = 32;
    localparam int INSTR_WD = 4;
    localparam int RSP_WD   = 2;
    localparam int TAG_WD   = 2;
    localparam int QDEPTH   = 4;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [0:NPORT*INSTR_WD-1] op = '0;
    logic [0:NPORT*REG_WD-1]   data_in = '0;
    logic [0:NPORT*TAG_WD-1]   tag_in = '0;
    logic [0:NPORT-1]          busy;
    logic [0:NPORT*RSP_WD-1]   resp;
    logic [0:NPORT*REG_WD-1]   data_out;
    logic [0:NPORT*TAG_WD-1]   tag_out;

    calc_multiport_engine #(
        .NPORT(NPORT), .REG_WD(REG_WD), .INSTR_WD(INSTR_WD),
        .RSP_WD(RSP_WD), .TAG_WD(TAG_WD), .QDEPTH(QDEPTH)
    ) dut (
        .clock(clock), .reset(reset), .op(op), .data_in(data_in), .tag_in(tag_in),
        .busy(busy), .resp(resp), .data_out(data_out), .tag_out(tag_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0]  drv_op   [NPORT];
    logic [31:0] drv_data [NPORT];
    logic [1:0]  drv_tag  [NPORT];
    bit          h_second [NPORT];

    // Reference model: per-port queue of accepted commands plus round-robin pointer.
    cmd_t        mq [NPORT][$];
    bit          m_pend     [NPORT];
    cmd_t        m_pend_cmd [NPORT];
    bit          m_skip     [NPORT];
    int          m_last;
    logic [1:0]  exp_resp [NPORT];
    logic [31:0] exp_data [NPORT];
    logic [1:0]  exp_tag  [NPORT];
    int          m_acc   [NPORT];
    int          got_rsp [NPORT];

    function automatic logic [1:0] dut_resp(int p);
        return resp[p*RSP_WD +: RSP_WD];
    endfunction
    function automatic logic [31:0] dut_data(int p);
        return data_out[p*REG_WD +: REG_WD];
    endfunction
    function automatic logic [1:0] dut_tag(int p);
        return tag_out[p*TAG_WD +: TAG_WD];
    endfunction

    function automatic bit model_busy(int p);
        return (mq[p].size() + (m_pend[p] ? 1 : 0)) >= QDEPTH;
    endfunction

    function automatic logic [33:0] ref_alu(cmd_t c);
        longint unsigned s;
        case (c.op)
            4'd1: begin
                s = longint'(c.a) + longint'(c.b);
                if (s >= 64'h1_0000_0000) return {2'd2, 32'd0};
                return {2'd1, c.a + c.b};
            end
            4'd2: begin
                if (c.b > c.a) return {2'd2, 32'd0};
                return {2'd1, c.a - c.b};
            end
            4'd5: return {2'd1, c.a << (c.b % 32)};
            4'd6: return {2'd1, c.a >> (c.b % 32)};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 7))
            0, 1:    return 4'd1;
            2:       return 4'd2;
            3:       return 4'd5;
            4:       return 4'd6;
            5:       return 4'd3;
            6:       return 4'd2;
            default: return 4'd15;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPORT; p++) begin
            mq[p].delete();
            m_pend[p]   = 1'b0;
            m_skip[p]   = 1'b0;
            exp_resp[p] = '0;
            exp_data[p] = '0;
            exp_tag[p]  = '0;
            h_second[p] = 1'b0;
        end
        m_last = NPORT - 1;
    endtask

    // Advance the model across one clock edge using the inputs being driven now.
    task automatic model_step();
        bit          b [NPORT];
        bit          found;
        int          start;
        int          p;
        cmd_t        c;
        logic [33:0] r;
        for (int q = 0; q < NPORT; q++) begin
            b[q]        = model_busy(q);
            exp_resp[q] = '0;
            exp_data[q] = '0;
            exp_tag[q]  = '0;
        end
        found = 1'b0;
        start = m_last;
        for (int i = 1; i <= NPORT; i++) begin
            p = (start + i) % NPORT;
            if (!found && mq[p].size() != 0) begin
                found       = 1'b1;
                c           = mq[p].pop_front();
                r           = ref_alu(c);
                exp_resp[p] = r[33:32];
                exp_data[p] = r[31:0];
                exp_tag[p]  = c.tag;
                m_last      = p;
            end
        end
        for (int q = 0; q < NPORT; q++) begin
            if (m_pend[q]) begin
                c   = m_pend_cmd[q];
                c.b = drv_data[q];
                mq[q].push_back(c);
                m_pend[q] = 1'b0;
            end else if (m_skip[q]) begin
                m_skip[q] = 1'b0;
            end else if (drv_op[q] != 4'd0) begin
                if (b[q]) begin
                    m_skip[q] = 1'b1;
                end else begin
                    m_pend[q]     = 1'b1;
                    m_pend_cmd[q] = {drv_op[q], drv_tag[q], drv_data[q], 32'd0};
                    m_acc[q]++;
                end
            end
        end
    endtask

    task automatic pack_inputs();
        for (int p = 0; p < NPORT; p++) begin
            op[p*INSTR_WD +: INSTR_WD] = drv_op[p];
            data_in[p*REG_WD +: REG_WD] = drv_data[p];
            tag_in[p*TAG_WD +: TAG_WD]  = drv_tag[p];
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic cycle();
        pack_inputs();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_drv();
        for (int p = 0; p < NPORT; p++) begin
            drv_op[p]   = '0;
            drv_data[p] = '0;
            drv_tag[p]  = '0;
        end
    endtask

    // Host protocol: every op cycle is followed by its operand cycle.
    task automatic host_drive(int p, bit allow_new);
        if (h_second[p]) begin
            drv_op[p]   = 4'($urandom_range(0, 15));
            drv_data[p] = $urandom;
            drv_tag[p]  = 2'($urandom_range(0, 3));
            h_second[p] = 1'b0;
        end else if (allow_new && $urandom_range(0, 9) < 8) begin
            drv_op[p]   = pick_op();
            drv_data[p] = $urandom;
            drv_tag[p]  = 2'($urandom_range(0, 3));
            h_second[p] = 1'b1;
        end else begin
            drv_op[p]   = '0;
            drv_data[p] = $urandom;
            drv_tag[p]  = '0;
        end
    endtask

    task automatic issue(int p, logic [3:0] o, logic [31:0] a, logic [31:0] b, logic [1:0] t);
        $display("issue port %0d op %0d a %08h b %08h tag %0d", p, o, a, b, t);
        idle_drv();
        drv_op[p]   = o;
        drv_data[p] = a;
        drv_tag[p]  = t;
        cycle();
        idle_drv();
        drv_data[p] = b;
        cycle();
    endtask

    task automatic test_reset();
        idle_drv();
        pack_inputs();
        @(posedge clock);
        #1;
        n_cmp++; if (resp !== '0) begin n_fail++; $display("FAIL reset_resp got %h want 0", resp); end
        n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
        n_cmp++; if (tag_out !== '0) begin n_fail++; $display("FAIL reset_tag got %h want 0", tag_out); end
        n_cmp++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        n_cmp++; if (resp !== '0) begin n_fail++; $display("FAIL post_reset_resp got %h want 0", resp); end
    endtask

    task automatic test_all_ports();
        idle_drv();
        for (int p = 0; p < NPORT; p++) begin
            drv_op[p]   = 4'd1;
            drv_data[p] = 32'(p + 1);
            drv_tag[p]  = 2'(p);
        end
        cycle();
        for (int p = 0; p < NPORT; p++) begin
            drv_op[p]   = 4'd0;
            drv_data[p] = 32'd10;
        end
        cycle();
        idle_drv();
        for (int k = 0; k < NPORT; k++) begin
            cycle();
            $display("all_ports cycle t+%0d resp %h tag %h", k + 3, resp, tag_out);
            for (int p = 0; p < NPORT; p++) begin
                n_cmp++;
                if (dut_resp(p) !== ((p == k) ? 2'd1 : 2'd0)) begin
                    n_fail++;
                    $display("FAIL all_ports_resp t+%0d port %0d got %0d want %0d", k + 3, p, dut_resp(p), (p == k) ? 1 : 0);
                end
            end
            n_cmp++;
            if (dut_data(k) !== 32'(k + 11) || dut_tag(k) !== 2'(k)) begin
                n_fail++;
                $display("FAIL all_ports_data port %0d got %08h/%0d want %08h/%0d", k, dut_data(k), dut_tag(k), k + 11, k);
            end
        end
    endtask

    task automatic test_single_add();
        issue(0, 4'd1, 32'h1, 32'h2, 2'd1);
        n_cmp++; if (resp !== '0) begin n_fail++; $display("FAIL add_early got %h want 0", resp); end
        idle_drv();
        cycle();
        $display("add port 0 resp %0d data %08h tag %0d", dut_resp(0), dut_data(0), dut_tag(0));
        n_cmp++;
        if (dut_resp(0) !== 2'd1 || dut_data(0) !== 32'h3 || dut_tag(0) !== 2'd1) begin
            n_fail++;
            $display("FAIL add_result got %0d/%08h/%0d want 1/00000003/1", dut_resp(0), dut_data(0), dut_tag(0));
        end
        n_cmp++;
        if (resp[RSP_WD:NPORT*RSP_WD-1] !== '0) begin
            n_fail++;
            $display("FAIL add_others got %h want 0", resp);
        end
        cycle();
        n_cmp++; if (resp !== '0) begin n_fail++; $display("FAIL add_one_cycle got %h want 0", resp); end
    endtask

    task automatic test_alu_port2();
        logic [3:0]  t_op  [5] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
        logic [31:0] t_a   [5] = '{32'hFFFF_FFFF, 32'h1, 32'h5, 32'h1, 32'h8000_0000};
        logic [31:0] t_b   [5] = '{32'h1, 32'h2, 32'h6, 32'h21, 32'd31};
        logic [1:0]  t_rsp [5] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        logic [31:0] t_res [5] = '{32'h0, 32'h0, 32'h0, 32'h2, 32'h1};
        for (int i = 0; i < 5; i++) begin
            issue(2, t_op[i], t_a[i], t_b[i], 2'(i));
            idle_drv();
            cycle();
            $display("alu port 2 op %0d resp %0d data %08h tag %0d", t_op[i], dut_resp(2), dut_data(2), dut_tag(2));
            n_cmp++;
            if (dut_resp(2) !== t_rsp[i] || dut_data(2) !== t_res[i] || dut_tag(2) !== 2'(i)) begin
                n_fail++;
                $display("FAIL alu_op%0d got %0d/%08h/%0d want %0d/%08h/%0d", t_op[i],
                         dut_resp(2), dut_data(2), dut_tag(2), t_rsp[i], t_res[i], i);
            end
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        int busy_seen = 0;
        for (int p = 0; p < NPORT; p++) begin
            m_acc[p]   = 0;
            got_rsp[p] = 0;
        end
        for (int c = 0; c < 240; c++) begin
            for (int p = 0; p < NPORT; p++) host_drive(p, c < 200);
            cycle();
            for (int p = 0; p < NPORT; p++) begin
                n_cmp++;
                if ({dut_resp(p), dut_data(p), dut_tag(p)} !== {exp_resp[p], exp_data[p], exp_tag[p]}) begin
                    n_fail++;
                    $display("FAIL b2b_result cyc %0d port %0d got %0d/%08h/%0d want %0d/%08h/%0d", c, p,
                             dut_resp(p), dut_data(p), dut_tag(p), exp_resp[p], exp_data[p], exp_tag[p]);
                end
                n_cmp++;
                if (busy[p] !== model_busy(p)) begin
                    n_fail++;
                    $display("FAIL b2b_busy cyc %0d port %0d got %b want %b", c, p, busy[p], model_busy(p));
                end
                if (busy[p] === 1'b1) busy_seen++;
                if (dut_resp(p) != 2'd0) begin
                    got_rsp[p]++;
                    $display("b2b port %0d resp %0d data %08h tag %0d", p, dut_resp(p), dut_data(p), dut_tag(p));
                end
            end
        end
        for (int p = 0; p < NPORT; p++) begin
            n_cmp++;
            if (got_rsp[p] !== m_acc[p]) begin
                n_fail++;
                $display("FAIL b2b_count port %0d got %0d want %0d", p, got_rsp[p], m_acc[p]);
            end
        end
        n_cmp++;
        if ((busy_seen > 0) !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_seen got %0d want >0", busy_seen);
        end
    endtask

    task automatic test_reset_mid();
        bit ready = 1'b0;
        for (int i = 0; i < 100 && !ready; i++) begin
            for (int p = 0; p < NPORT; p++) host_drive(p, p != 1);
            cycle();
            ready = (mq[3].size() >= 3) && !h_second[1];
        end
        if (!ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL reset_mid_setup got timeout want port 3 backlog");
        end
        for (int p = 0; p < NPORT; p++) if (p != 1) host_drive(p, 1'b0);
        drv_op[1]   = 4'd1;
        drv_data[1] = 32'h10;
        drv_tag[1]  = 2'd3;
        cycle();
        // Port 1 is now in its operand cycle; reset lands mid-cycle.
        for (int p = 0; p < NPORT; p++) if (p != 1) host_drive(p, 1'b0);
        drv_op[1]   = 4'd0;
        drv_data[1] = 32'h20;
        pack_inputs();
        #3;
        reset = 1'b1;
        #1;
        $display("reset_mid resp %h busy %b", resp, busy);
        n_cmp++; if (resp !== '0) begin n_fail++; $display("FAIL reset_mid_resp got %h want 0", resp); end
        n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_mid_data got %h want 0", data_out); end
        n_cmp++; if (tag_out !== '0) begin n_fail++; $display("FAIL reset_mid_tag got %h want 0", tag_out); end
        n_cmp++; if (busy !== '0) begin n_fail++; $display("FAIL reset_mid_busy got %b want 0", busy); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        idle_drv();
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if (resp !== '0) begin n_fail++; $display("FAIL reset_mid_stale cyc %0d got %h want 0", i, resp); end
        end
        issue(3, 4'd1, 32'd5, 32'd6, 2'd2);
        n_cmp++; if (resp !== '0) begin n_fail++; $display("FAIL reset_mid_early got %h want 0", resp); end
        idle_drv();
        cycle();
        $display("reset_mid port 3 resp %0d data %08h tag %0d", dut_resp(3), dut_data(3), dut_tag(3));
        n_cmp++;
        if (dut_resp(3) !== 2'd1 || dut_data(3) !== 32'd11 || dut_tag(3) !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_mid_next got %0d/%08h/%0d want 1/0000000b/2", dut_resp(3), dut_data(3), dut_tag(3));
        end
        cycle();
    endtask

    initial begin
        idle_drv();
        model_reset();
        for (int p = 0; p < NPORT; p++) begin
            m_acc[p]   = 0;
            got_rsp[p] = 0;
        end
        test_reset();
        test_all_ports();
        test_single_add();
        test_alu_port2();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_multiport_engine.md
# calc_multiport_engine

Parametrised multi-port calculator execution engine for the calculator design. Each of NPORT ports accepts tagged two-cycle commands into a private command FIFO. A single shared ALU is granted round-robin across non-empty FIFOs, one command per cycle. Each result returns on the issuing port with its tag. Per-port backpressure (`busy`) is added so ports no longer need to self-limit outstanding work.

## Interface
Parameters:
- `NPORT`, 4: number of ports.
- `REG_WD`, 32: operand/result width.
- `INSTR_WD`, 4: opcode width.
- `RSP_WD`, 2: response width.
- `TAG_WD`, 2: tag width.
- `QDEPTH`, 4: command FIFO depth per port, ≥2.

Ports. All vectors are MSB-first (`[0:N-1]`, bit 0 = MSB). Port p occupies slice `[p*W : p*W+W-1]` of each flattened vector.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op`  in  NPORT*INSTR_WD  per-port opcode; 0 = no-op.
- `data_in`  in  NPORT*REG_WD  operand1 in the op cycle, operand2 in the following cycle.
- `tag_in`  in  NPORT*TAG_WD  tag, sampled in the op cycle.
- `busy`  out  NPORT  1 = port cannot start a command this cycle.
- `resp`  out  NPORT*RSP_WD  0 none, 1 success, 2 overflow/underflow/invalid, 3 unused.
- `data_out`  out  NPORT*REG_WD  result.
- `tag_out`  out  NPORT*TAG_WD  tag of the command being responded to.

## Operation
- Capture per port, two states:
  - IDLE: when `op != 0` and `busy == 0`, latch op, tag and operand1, then go to OP2.
  - OP2: sample operand2 from `data_in`, push {op, tag, op1, op2}, return to IDLE. `op` is ignored in OP2.
- `op != 0` while `busy == 1`: the whole command (that cycle and the next) is discarded. No response is produced.
- `busy[p]` = (FIFO count + 1 if in OP2) ≥ QDEPTH. Combinational from registered state only.
- Arbiter:
  - Among ports with non-empty FIFOs, grant the first port found searching from (last_grant+1) mod NPORT.
  - Pop the granted head.
  - After reset, last_grant = NPORT-1, so port 0 wins first.
- ALU, unsigned REG_WD-bit:
  - 1 add: a carry out gives resp 2, data_out 0.
  - 2 sub: op2 > op1 gives resp 2, data_out 0.
  - 5 shift left, toward bit 0: amount = low clog2(REG_WD) bits of op2; all other op2 bits are ignored. Zero fill.
  - 6 shift right: same amount rule; zero fill.
  - Any other nonzero opcode gives resp 2, data_out 0.
- Result is registered onto the granted port's `resp`/`data_out`/`tag_out` for exactly one cycle. A port not receiving a result in a cycle drives resp 0, data_out 0, tag_out 0.
- Per-port responses stay in command order.
- Tags are passed through unchecked. Duplicate tags are legal.
- Push and pop on the same port in the same cycle leave the count unchanged.

## Timing
- Reset (asynchronous assertion, removal synchronous to `clock`):
  - All FIFOs emptied and capture state set to IDLE.
  - last_grant = NPORT-1.
  - `busy` = 0, `resp` = 0, `data_out` = 0, `tag_out` = 0, immediately on assertion.
  - A command mid-capture or queued is lost with no response.
- Latency with an idle engine: op in cycle t, operand2 in t+1, push at end of t+1, grant and compute in t+2, response visible in cycle t+3.
- Contention adds one cycle per port granted ahead. Worst case for a head entry is NPORT-1 extra cycles.
- Throughput is one result per cycle engine-wide. A single port can start a command every 2 cycles.
- A port may start a new op in the cycle immediately after OP2.

## Test plan
- Port 0: add 0x00000001 + 0x00000002, tag 1 at cycle t -> port 0 shows resp 1, data_out 0x00000003, tag_out 1 in cycle t+3 only; other ports show resp 0.
- Port 2:
  - Add 0xFFFFFFFF + 0x00000001 -> resp 2, data 0.
  - Sub 1 − 2 -> resp 2, data 0.
  - Opcode 0x3 -> resp 2.
  - Shift left 0x00000001 by 0x00000021 -> resp 1, 0x00000002 (amount 1).
  - Shift right 0x80000000 by 31 -> 0x00000001.
- All 4 ports issue add with tags 0–3 in the same cycle t -> responses on ports 0, 1, 2, 3 in cycles t+3, t+4, t+5, t+6 respectively.
- All ports issue back-to-back commands continuously:
  - Each port's `busy` asserts once its count reaches 4.
  - Commands started while `busy` yield no response.
  - Per port, response count equals accepted count, in order with matching tags.
- Assert reset during OP2 of port 1 with 3 entries queued on port 3:
  - All outputs go to 0 immediately and `busy` goes to 0.
  - No responses appear after reset is released.
  - The next port 3 command completes at t+3.
